// File: rtl/mux_rr_stream.sv
// N-channel handshaked stream mux: fixed-select or round-robin choice of one
// input per cycle into a single registered output slot tagged with its channel.

module mux_rr_lane #(
  parameter int SELW = 2,
  parameter int K    = 0
) (
  input  logic            mode,
  input  logic [SELW-1:0] sel,
  input  logic            rr_hit,
  input  logic            acc,
  output logic            rdy
);
  // An out-of-range sel matches no lane, so nothing is offered in fixed mode.
  assign rdy = acc & (mode ? rr_hit : (sel == SELW'(K)));
endmodule

module mux_rr_stream #(
  parameter int NCH   = 4,
  parameter int WIDTH = 8,
  parameter int SELW  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_ch,
  output logic                 out_valid,
  input  logic                 out_ready
);

  logic [SELW-1:0]  ptr;
  logic             acc;
  logic [NCH-1:0]   rr_oh;
  logic             rr_found;
  logic [NCH-1:0]   take;
  logic             xfer;
  logic [SELW-1:0]  xfer_ch;
  logic [SELW-1:0]  ptr_nxt;
  logic [WIDTH-1:0] xfer_data;

  // Slot is free, or being emptied this cycle; held low through reset.
  assign acc = !rst & (!out_valid | out_ready);

  // First valid channel at or after ptr, wrapping modulo NCH.
  always_comb begin
    rr_oh    = '0;
    rr_found = 1'b0;
    for (int j = 0; j < NCH; j++) begin
      for (int k = 0; k < NCH; k++) begin
        if (!rr_found && (k == (int'(ptr) + j) % NCH) && in_valid[k]) begin
          rr_oh[k] = 1'b1;
          rr_found = 1'b1;
        end
      end
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_lane
    mux_rr_lane #(.SELW(SELW), .K(k)) u_lane (
      .mode   (mode),
      .sel    (sel),
      .rr_hit (rr_oh[k]),
      .acc    (acc),
      .rdy    (in_ready[k])
    );
  end

  assign take = in_valid & in_ready;
  assign xfer = |take;

  // At most one bit of take is set, so this is a plain one-hot select.
  always_comb begin
    xfer_ch   = '0;
    xfer_data = '0;
    for (int k = 0; k < NCH; k++) begin
      if (take[k]) begin
        xfer_ch   = SELW'(k);
        xfer_data = in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  assign ptr_nxt = (xfer_ch == SELW'(NCH-1)) ? '0 : xfer_ch + SELW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      ptr       <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= xfer_data;
      out_ch    <= xfer_ch;
      if (mode) ptr <= ptr_nxt;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_rr_stream.sv
// Scoreboard bench for mux_rr_stream: a reference model predicts in_ready and
// queues each accepted word, which is then matched against the output register.

module tb_mux_rr_stream;
  localparam int NCH = 4, WIDTH = 8, SELW = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0]       in_valid;
  logic [NCH-1:0]       in_ready;
  logic                 mode;
  logic [SELW-1:0]      sel;
  logic [WIDTH-1:0]     out_data;
  logic [SELW-1:0]      out_ch;
  logic                 out_valid;
  logic                 out_ready;

  typedef struct packed {
    logic [SELW-1:0]  ch;
    logic [WIDTH-1:0] data;
  } ent_t;

  ent_t            q[$];
  logic            m_ov;
  int              m_ptr;
  int              checks = 0;
  int              errors = 0;
  int              wrap_exp[4] = '{3, 1, 3, 1};

  always #5 clk = ~clk;

  mux_rr_stream #(.NCH(NCH), .WIDTH(WIDTH), .SELW(SELW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_data(input int base);
    for (int k = 0; k < NCH; k++) in_data[k*WIDTH +: WIDTH] = WIDTH'(base + k);
  endtask

  // One clock: predict and check mid-cycle, then advance the model at the edge.
  task automatic cyc();
    logic [NCH-1:0] er;
    logic [NCH-1:0] tk;
    logic           acc;
    int             kk;
    int             idx;
    ent_t           e;
    #2;
    acc = !rst && (!m_ov || out_ready);
    er  = '0;
    if (acc) begin
      if (!mode) begin
        if (int'(sel) < NCH) er[sel] = 1'b1;
      end else begin
        for (int j = 0; j < NCH; j++) begin
          idx = (m_ptr + j) % NCH;
          if (in_valid[idx] && er == '0) er[idx] = 1'b1;
        end
      end
    end
    chk("in_ready", 32'(in_ready), 32'(er));
    if (!rst) begin
      chk("out_valid", 32'(out_valid), 32'(m_ov));
      if (m_ov) begin
        chk("sb_nonempty", 32'(q.size() > 0), 32'd1);
        if (q.size() > 0) begin
          chk("out_data", 32'(out_data), 32'(q[0].data));
          chk("out_ch", 32'(out_ch), 32'(q[0].ch));
        end
      end
    end
    tk = in_valid & er;
    kk = -1;
    for (int k = 0; k < NCH; k++) if (tk[k]) kk = k;
    @(posedge clk);
    if (rst) begin
      m_ov  = 1'b0;
      m_ptr = 0;
      q.delete();
    end else begin
      if (m_ov && out_ready && q.size() > 0) void'(q.pop_front());
      if (kk >= 0) begin
        e.ch   = SELW'(kk);
        e.data = in_data[kk*WIDTH +: WIDTH];
        q.push_back(e);
        m_ov = 1'b1;
        if (mode) m_ptr = (kk + 1) % NCH;
      end else if (out_ready) begin
        m_ov = 1'b0;
      end
    end
    #1;
  endtask

  initial begin
    m_ov      = 1'b0;
    m_ptr     = 0;
    rst       = 1'b1;
    mode      = 1'b1;
    sel       = '0;
    in_valid  = '1;
    out_ready = 1'b1;
    set_data(8'h80);

    // Reset with every channel requesting.
    cyc();
    cyc();
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_ch", 32'(out_ch), 32'd0);
    chk("rst_first_grant", 32'(in_ready), 32'b0001);

    // RR fairness: all valid, full throughput.
    for (int i = 0; i < 8; i++) begin
      set_data(16 * i);
      cyc();
      chk("rr_seq", 32'(out_ch), 32'(i % NCH));
      chk("rr_seq_vld", 32'(out_valid), 32'd1);
    end

    // Fixed select of ch2, then move sel to an idle ch3 and drain.
    mode = 1'b0;
    sel  = 2'd2;
    in_valid = 4'b0100;
    in_data[2*WIDTH +: WIDTH] = 8'hA5;
    #1;
    chk("fix_ready", 32'(in_ready), 32'b0100);
    cyc();
    chk("fix_data", 32'(out_data), 32'hA5);
    chk("fix_ch", 32'(out_ch), 32'd2);
    sel = 2'd3;
    in_valid = '0;
    cyc();
    chk("fix_drain", 32'(out_valid), 32'd0);

    // Park ptr at 2 via a lone ch1 grant, then ch1/ch3 alternate.
    mode = 1'b1;
    in_valid = 4'b0010;
    set_data(8'h40);
    cyc();
    in_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      set_data(8'h50 + 16 * i);
      #1;
      chk("skip_no_0_2", 32'(in_ready & 4'b0101), 32'd0);
      cyc();
      chk("skip_order", 32'(out_ch), 32'(wrap_exp[i]));
    end

    // Backpressure holding 0x3C, then release with same-cycle accept.
    mode = 1'b0;
    sel  = 2'd0;
    in_valid = 4'b0001;
    in_data[0 +: WIDTH] = 8'h3C;
    cyc();
    out_ready = 1'b0;
    in_valid  = '1;
    set_data(8'h60);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_ready", 32'(in_ready), 32'd0);
      cyc();
      chk("stall_data", 32'(out_data), 32'h3C);
    end
    out_ready = 1'b1;
    in_valid  = 4'b0001;
    in_data[0 +: WIDTH] = 8'h5A;
    #1;
    chk("release_ready", 32'(in_ready), 32'b0001);
    cyc();
    chk("release_data", 32'(out_data), 32'h5A);
    chk("release_vld", 32'(out_valid), 32'd1);

    // Reset while holding a word with ptr=3.
    mode = 1'b1;
    in_valid = 4'b0100;
    set_data(8'h70);
    cyc();
    out_ready = 1'b0;
    in_valid  = '0;
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    chk("mid_rst_vld", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    in_valid  = '1;
    set_data(8'h90);
    #1;
    chk("mid_rst_grant", 32'(in_ready), 32'b0001);
    cyc();
    chk("mid_rst_ch", 32'(out_ch), 32'd0);

    // Random traffic across both modes and backpressure.
    for (int i = 0; i < 300; i++) begin
      in_valid  = NCH'($urandom);
      mode      = 1'($urandom);
      sel       = SELW'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      set_data(int'($urandom_range(0, 255)));
      cyc();
    end

    in_valid  = '0;
    out_ready = 1'b1;
    cyc();
    cyc();
    chk("sb_drained", 32'(q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_rr_stream.md
Name: mux_rr_stream

Overview:
Parametrised N-channel stream multiplexer. It is the sequential, handshaked successor to our gate-level 4:1 mux. N input streams of WIDTH bits each carry valid/ready. One channel is chosen per cycle, either by an external select (fixed mode) or by a round-robin arbiter (RR mode). The chosen word is captured in a one-entry output register with valid/ready and a channel tag. The block sits between parallel producers and a single shared consumer, such as a bus or serialiser.

Parameters:
NCH, 4, number of input channels (>=2)
WIDTH, 8, data width per channel
SELW, 2, select/tag width; must satisfy 2**SELW >= NCH

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, synchronous, active-high
in_data  in  NCH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
in_valid  in  NCH  per-channel valid
in_ready  out  NCH  per-channel ready (combinational)
mode  in  1  0 = fixed select, 1 = round-robin
sel  in  SELW  channel select, used only when mode=0
out_data  out  WIDTH  registered output word
out_ch  out  SELW  index of channel that produced out_data
out_valid  out  1  output register holds a word
out_ready  in  1  consumer accepts out_data this cycle

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high; all state changes on rising clk.
- Reset values: out_valid=0, out_data=0, out_ch=0, RR pointer ptr=0. in_ready is combinational and therefore 0 during and after reset until the accept term is true.
- Reset mid-operation: any held word is dropped and not delivered. ptr returns to 0.
- Accept term: acc = !out_valid | out_ready. This allows one transfer per cycle while the consumer keeps out_ready high, i.e. full throughput.
- Fixed mode (mode=0):
  - in_ready[sel] = acc; all other in_ready = 0.
  - If sel >= NCH, all in_ready = 0 and no transfer occurs.
  - in_ready does not depend on in_valid.
- RR mode (mode=1):
  - grant = the first k with in_valid[k]=1, searching ptr, ptr+1, ..., wrapping modulo NCH.
  - in_ready[grant] = acc; all others 0.
  - If no in_valid is set, all in_ready = 0.
  - In this mode in_ready may depend on in_valid.
- Transfer condition: in_valid[k] & in_ready[k]. On a transfer:
  - out_data <= channel k data, out_ch <= k, out_valid <= 1.
  - In RR mode only: ptr <= (k+1) mod NCH, with wrap from NCH-1 to 0.
- Drain with no new transfer: if out_valid & out_ready and nothing is transferred, out_valid <= 0. out_data and out_ch hold their values.
- Stall: while out_valid & !out_ready, out_data and out_ch are stable and all in_ready = 0.
- Latency: exactly 1 cycle from input transfer to out_valid.
- Mode switching:
  - A change of mode or sel takes effect combinationally in the same cycle.
  - ptr is retained across fixed-mode periods and is only updated by RR grants.
- No word is ever duplicated or lost; each input transfer produces exactly one output transfer.

Test Plan:
- Reset: assert rst for 2 cycles while all in_valid=1 -> out_valid=0, out_data=0, out_ch=0, all in_ready=0 during reset. In the first cycle after release in RR mode, ch0 is granted.
- Fixed mode, sel=2, ch2 data 0xA5 valid, out_ready=1 -> in_ready=4'b0100. Next cycle out_data=0xA5, out_ch=2, out_valid=1. Now set sel=3 with ch3 invalid -> out_valid drops to 0 after the drain.
- RR fairness: NCH=4, all in_valid=1 with distinct data, out_ready=1 for 8 cycles -> out_ch sequence 0,1,2,3,0,1,2,3 at one word per cycle.
- RR skip and wrap: only ch1 and ch3 valid, ptr=2 -> grant order 3,1,3,1. Channels 0 and 2 never see in_ready=1.
- Backpressure: out_valid=1 holding 0x3C, out_ready=0 for 3 cycles -> out_data stays 0x3C and all in_ready=0. Raise out_ready with ch0 valid -> the same cycle accepts ch0, and the next cycle shows ch0 data with no gap.
- Reset mid-operation: out_valid=1, ptr=3, assert rst for 1 cycle -> out_valid=0. The next RR grant with all channels valid goes to ch0.
